pipe_skid_stage: RTL and testbench

- Generalised pipeline-stage register for the 5-stage core: a parametrised payload moves between two pipeline stages under a valid/ready handshake.
- A 2-entry skid buffer lets the downstream stage stall without a combinational ready path back to the upstream stage.
- A synchronous flush handles branch mispredicts.
- It replaces the fixed-field F/D, D/E and E/M registers. Each instance packs its own fields into the payload.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_skid_stage.sv | 132 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage registers of the 5-stage core.
// Optional feature macro used by pipe_skid_stage: PIPE_SKID_PERF_EN.
package pipe_pkg;

    // Occupancy of a skid stage: no entry, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Default payload: instr(32) + pc(32) + pcplus4(32) + predict bit(1).
    localparam int PIPE_PAYLOAD_WIDTH = 97;

    // Field positions for the F/D packing.
    localparam int PRED_BIT = 0;
    localparam int PCP4_LSB = 1;
    localparam int PC_LSB   = 33;
    localparam int INSTR_LSB = 65;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Increment on qualifying cycles, hold once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline-stage register with a 2-entry skid buffer and synchronous flush.
// in_ready/out_valid are registered, so there is no combinational path from
// out_ready back to in_ready. Optional macro PIPE_SKID_PERF_EN adds stall and
// flush cycle counters (stall_cnt, flush_cnt).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                      PAYLOAD_WIDTH = PIPE_PAYLOAD_WIDTH,
    parameter logic [PAYLOAD_WIDTH-1:0] CLR_VALUE    = '0,
    parameter int                      CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
`endif
);

    skid_state_t              r_state;
    skid_state_t              w_state_next;
    logic [PAYLOAD_WIDTH-1:0] r_main;
    logic [PAYLOAD_WIDTH-1:0] w_main_next;
    logic [PAYLOAD_WIDTH-1:0] r_skid;
    logic [PAYLOAD_WIDTH-1:0] w_skid_next;
    logic                     r_out_valid;
    logic                     r_in_ready;
    logic                     w_accept;
    logic                     w_fire;

    assign w_accept = in_valid && r_in_ready;
    assign w_fire   = r_out_valid && out_ready;

    // State, storage and handshake flags; flags are decoded from the next state
    // so they stay pure flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= CLR_VALUE;
            r_skid      <= CLR_VALUE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_main      <= w_main_next;
            r_skid      <= w_skid_next;
            r_out_valid <= (w_state_next != EMPTY);
            r_in_ready  <= (w_state_next != FULL);
        end
    end

    // Next-state and storage moves; flush wins over every handshake transition.
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush) begin
            w_state_next = EMPTY;
            w_main_next  = CLR_VALUE;
            w_skid_next  = CLR_VALUE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_next  = in_data;
                        w_state_next = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_fire) begin
                        w_main_next = in_data;
                    end else if (w_accept) begin
                        w_skid_next  = in_data;
                        w_state_next = FULL;
                    end else if (w_fire) begin
                        w_main_next  = CLR_VALUE;
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_fire) begin
                        w_main_next  = r_skid;
                        w_skid_next  = CLR_VALUE;
                        w_state_next = ONE;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                    w_main_next  = CLR_VALUE;
                    w_skid_next  = CLR_VALUE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

`ifdef PIPE_SKID_PERF_EN
    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (r_out_valid && !out_ready),
        .count(stall_cnt)
    );

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush),
        .count(flush_cnt)
    );
`else
    // Counter width only matters when the counters are built.
    if (CNT_WIDTH < 1) begin : g_no_counters
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random
// phase, all compared against a queue-based model of a 2-deep FIFO stage.
module tb_pipe_skid_stage;

    localparam int          PW  = 16;
    localparam logic [PW-1:0] CLR = 16'hC1C1;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_skid_stage #(
        .PAYLOAD_WIDTH(PW),
        .CLR_VALUE    (CLR),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit verbose = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most two payloads; the head is what
    // downstream sees, and an empty stage shows the clear value.
    logic [PW-1:0] q[$];
    int            m_stall = 0;
    int            m_flush = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            bit m_acc, m_fire;
            m_acc  = in_valid && (q.size() < 2);
            m_fire = (q.size() > 0) && out_ready;
            if (m_fire && verbose)
                $display("xfer out %0h", q[0]);
            if ((q.size() > 0) && !out_ready && m_stall < (1 << CW) - 1) m_stall++;
            if (flush && m_flush < (1 << CW) - 1) m_flush++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_fire) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
            end
        end
    end

    // Every-cycle comparison, half a period away from the active edge.
    always @(negedge clk) begin
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("out_data",  64'(out_data),  64'((q.size() > 0) ? q[0] : CLR));
`ifdef PIPE_SKID_PERF_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    initial begin
        do_reset();
        step();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_data",  64'(out_data),  64'(CLR));

        // Streaming at full rate.
        drive(1, 16'h1, 1, 0); step();
        check("stream d1", 64'(out_data), 64'h1);
        check("stream rdy1", 64'(in_ready), 64'd1);
        drive(1, 16'h2, 1, 0); step();
        check("stream d2", 64'(out_data), 64'h2);
        drive(1, 16'h3, 1, 0); step();
        check("stream d3", 64'(out_data), 64'h3);
        check("stream rdy3", 64'(in_ready), 64'd1);
        drive(0, 16'hFFFF, 1, 0); step();
        check("stream drain", 64'(out_valid), 64'd0);

        // Backpressure fills the skid; release drains in order.
        drive(1, 16'hA, 0, 0); step();
        check("bp rdy after A", 64'(in_ready), 64'd1);
        drive(1, 16'hB, 0, 0); step();
        check("bp rdy after B", 64'(in_ready), 64'd0);
        check("bp head A", 64'(out_data), 64'hA);
        drive(0, 16'h0, 1, 0); step();
        check("bp head B", 64'(out_data), 64'hB);
        check("bp rdy back", 64'(in_ready), 64'd1);
        step();
        check("bp empty", 64'(out_valid), 64'd0);
        check("bp clr", 64'(out_data), 64'(CLR));

        // Flush while full, with an incoming payload that must be dropped.
        drive(1, 16'h11, 0, 0); step();
        drive(1, 16'h12, 0, 0); step();
        drive(1, 16'hC, 0, 1); step();
        drive(0, 16'h0, 1, 0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush out_data",  64'(out_data),  64'(CLR));
        check("flush in_ready",  64'(in_ready),  64'd1);
        step(); step();
        check("flush no C", 64'(out_valid), 64'd0);

        // Accept and fire in the same cycle while holding one entry.
        drive(1, 16'h5, 1, 0); step();
        check("af head 5", 64'(out_data), 64'h5);
        drive(1, 16'h6, 1, 0); step();
        check("af head 6", 64'(out_data), 64'h6);
        check("af valid", 64'(out_valid), 64'd1);
        check("af rdy", 64'(in_ready), 64'd1);
        drive(0, 16'h0, 1, 0); step();

        // Asynchronous reset while full takes effect before the next edge.
        drive(1, 16'h21, 0, 0); step();
        drive(1, 16'h22, 0, 0); step();
        drive(0, 16'h0, 0, 0);
        check("arst pre full", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst in_ready",  64'(in_ready),  64'd1);
        check("arst out_data",  64'(out_data),  64'(CLR));
        #2 rst = 1'b0;
        step();

        // Random traffic against the model.
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), PW'($urandom), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 4));
            step();
        end
        drive(0, 16'h0, 1, 0);
        step(); step(); step();
        check("rand drained", 64'(out_valid), 64'd0);

`ifdef PIPE_SKID_PERF_EN
        // Saturation of the stall counter and flush counting after a reset.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        drive(1, 16'h77, 0, 0); step();
        drive(0, 16'h0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("stall sat", 64'(stall_cnt), 64'd15);
        drive(0, 16'h0, 1, 1);
        for (int i = 0; i < 3; i++) step();
        drive(0, 16'h0, 1, 0); step();
        check("flush cnt", 64'(flush_cnt), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
